// File: rtl/palette_store.sv
// Writable colour palette with NUM_PORTS registered read ports and a default reload after reset.
// Latency: reads 1 cycle (rd_en before edge k -> rd_color/rd_valid after edge k); the reload takes NUM_ENTRIES cycles.
// Backpressure: none on reads; writes are accepted only while wr_ready is high and are dropped silently otherwise.
module palette_store #(
  parameter int NUM_ENTRIES = 16,
  parameter int COLOR_W     = 8,
  parameter int NUM_PORTS   = 2,
  parameter logic [NUM_ENTRIES*COLOR_W-1:0] DEFAULTS =
    128'hf6af_aa38_c900_3f00_6fea_f800_ef66_0700,
  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_PORTS-1:0]                rd_en,
  input  logic [NUM_PORTS-1:0][IDX_W-1:0]     rd_index,
  output logic [NUM_PORTS-1:0][COLOR_W-1:0]   rd_color,
  output logic [NUM_PORTS-1:0]                rd_valid,
  input  logic                                wr_en,
  input  logic [IDX_W-1:0]                    wr_index,
  input  logic [COLOR_W-1:0]                  wr_color,
  output logic                                wr_ready,
  output logic                                init_busy
);

  // One extra bit so the depth itself is representable for range checks.
  localparam logic [IDX_W:0]   DEPTH = NUM_ENTRIES[IDX_W:0];
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_ENTRIES - 1);

  typedef enum logic {INIT, READY} state_t;

  state_t                             state;
  state_t                             state_nxt;
  logic [IDX_W-1:0]                   init_cnt;
  logic [IDX_W-1:0]                   cnt_nxt;
  logic [COLOR_W-1:0]                 mem [NUM_ENTRIES];

  logic                               mem_we;
  logic [IDX_W-1:0]                   mem_addr;
  logic [COLOR_W-1:0]                 mem_dat;
  logic                               wr_acc;
  logic [NUM_PORTS-1:0][COLOR_W-1:0]  rd_dat;

  assign init_busy = (state == INIT);
  assign wr_ready  = (state == READY);

  // A CPU write lands only in READY, outside reset, and inside the table.
  assign wr_acc = wr_en & (state == READY) & ~rst & ({1'b0, wr_index} < DEPTH);

  // Next state and the single storage write port, shared by reload and CPU writes.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = init_cnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_dat   = '0;
    unique case (state)
      INIT: begin
        mem_we   = ~rst;
        mem_addr = init_cnt;
        mem_dat  = DEFAULTS[init_cnt*COLOR_W +: COLOR_W];
        if (init_cnt == LAST) begin
          state_nxt = READY;
        end else begin
          cnt_nxt = init_cnt + 1'b1;
        end
      end
      READY: begin
        if (wr_acc) begin
          mem_we   = 1'b1;
          mem_addr = wr_index;
          mem_dat  = wr_color;
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  // State register; reset restarts the reload from entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= cnt_nxt;
    end
  end

  // Storage has no reset; the reload sequence refills it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_dat;
    end
  end

  // Per-port lookup: out-of-range reads yield 0, a colliding accepted write is forwarded.
  always_comb begin
    rd_dat = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if ({1'b0, rd_index[p]} < DEPTH) begin
        if (wr_acc && (wr_index == rd_index[p])) begin
          rd_dat[p] = wr_color;
        end else begin
          rd_dat[p] = mem[rd_index[p]];
        end
      end
    end
  end

  // Registered read outputs; colour holds when the port is not serviced.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= '0;
      rd_color <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        rd_valid[p] <= rd_en[p] & (state == READY);
        if (rd_en[p] && (state == READY)) begin
          rd_color[p] <= rd_dat[p];
        end
      end
    end
  end

endmodule

// File: tb/tb_palette_store.sv
// Bench for palette_store: a 16-entry and a 12-entry instance share stimulus, each checked against its own model.
// Latency: checks sample outputs on the falling edge after each rising edge.
// Backpressure: the model drops writes whenever the palette is reloading.
module tb_palette_store;

  localparam int NP = 2;
  localparam int CW = 8;
  localparam int IW = 4;
  localparam logic [127:0] DEF = 128'hf6af_aa38_c900_3f00_6fea_f800_ef66_0700;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst;
  logic [NP-1:0]           rd_en;
  logic [NP-1:0][IW-1:0]   rd_index;
  logic                    wr_en;
  logic [IW-1:0]           wr_index;
  logic [CW-1:0]           wr_color;

  logic [NP-1:0][CW-1:0]   col_a, col_b;
  logic [NP-1:0]           val_a, val_b;
  logic                    wrdy_a, wrdy_b, busy_a, busy_b;

  palette_store #(.NUM_ENTRIES(16), .COLOR_W(CW), .NUM_PORTS(NP), .DEFAULTS(DEF)) dut_a (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_index(rd_index), .rd_color(col_a),
    .rd_valid(val_a), .wr_en(wr_en), .wr_index(wr_index), .wr_color(wr_color),
    .wr_ready(wrdy_a), .init_busy(busy_a));

  palette_store #(.NUM_ENTRIES(12), .COLOR_W(CW), .NUM_PORTS(NP), .DEFAULTS(DEF[95:0])) dut_b (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_index(rd_index), .rd_color(col_b),
    .rd_valid(val_b), .wr_en(wr_en), .wr_index(wr_index), .wr_color(wr_color),
    .wr_ready(wrdy_b), .init_busy(busy_b));

  // Default palette written out entry by entry, independent of the packed parameter.
  logic [7:0] dtab [16] = '{8'h00, 8'h07, 8'h66, 8'hef, 8'h00, 8'hf8, 8'hea, 8'h6f,
                            8'h00, 8'h3f, 8'h00, 8'hc9, 8'h38, 8'haa, 8'haf, 8'hf6};

  int total = 0;
  int bad   = 0;

  // Reference model: palette contents, whether it is usable, and how far the reload got.
  int                     depth [2] = '{16, 12};
  logic [7:0]             mm    [2][16];
  bit                     mready[2];
  int                     mfill [2];
  logic [NP-1:0]          ev    [2];
  logic [NP-1:0][CW-1:0]  ec    [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_rd(input logic e0, input int i0, input logic e1, input int i1);
    rd_en       = {e1, e0};
    rd_index[0] = IW'(i0);
    rd_index[1] = IW'(i1);
  endtask

  task automatic set_wr(input logic e, input int idx, input logic [7:0] c);
    wr_en    = e;
    wr_index = IW'(idx);
    wr_color = c;
  endtask

  // Advance one clock: predict from the model, then compare both instances.
  task automatic step();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mready[k] = 1'b0;
        mfill[k]  = 0;
        ev[k]     = '0;
        ec[k]     = '0;
      end else begin
        bit wacc;
        wacc = mready[k] && wr_en && (int'(wr_index) < depth[k]);
        for (int p = 0; p < NP; p++) begin
          if (mready[k] && rd_en[p]) begin
            ev[k][p] = 1'b1;
            if (int'(rd_index[p]) >= depth[k])            ec[k][p] = 8'h00;
            else if (wacc && wr_index == rd_index[p])     ec[k][p] = wr_color;
            else                                          ec[k][p] = mm[k][rd_index[p]];
          end else begin
            ev[k][p] = 1'b0;
          end
        end
        if (wacc) mm[k][wr_index] = wr_color;
        if (!mready[k]) begin
          mm[k][mfill[k]] = dtab[mfill[k]];
          mfill[k]++;
          if (mfill[k] == depth[k]) mready[k] = 1'b1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    for (int p = 0; p < NP; p++) begin
      check($sformatf("a.valid%0d", p), 32'(val_a[p]), 32'(ev[0][p]));
      check($sformatf("a.color%0d", p), 32'(col_a[p]), 32'(ec[0][p]));
      check($sformatf("b.valid%0d", p), 32'(val_b[p]), 32'(ev[1][p]));
      check($sformatf("b.color%0d", p), 32'(col_b[p]), 32'(ec[1][p]));
    end
    check("a.busy", 32'(busy_a), 32'(!mready[0]));
    check("a.wrdy", 32'(wrdy_a), 32'(mready[0]));
    check("b.busy", 32'(busy_b), 32'(!mready[1]));
    check("b.wrdy", 32'(wrdy_b), 32'(mready[1]));
  endtask

  // Release reset and count reload cycles; the optional write lands on reload cycle 3.
  task automatic reload(input bit poke, output int cnt_a, output int cnt_b);
    rst   = 1'b0;
    cnt_a = int'(busy_a);
    cnt_b = int'(busy_b);
    for (int i = 0; i < 40; i++) begin
      if (poke && i == 2) set_wr(1'b1, 2, 8'hff);
      else                set_wr(1'b0, 0, 8'h00);
      step();
      if (busy_a) cnt_a++;
      if (busy_b) cnt_b++;
    end
  endtask

  initial begin
    int ca, cb;
    rst = 1'b1;
    set_rd(1'b0, 0, 1'b0, 0);
    set_wr(1'b0, 0, 8'h00);

    // Reset sweep
    repeat (3) step();
    check("rst.color0", 32'(col_a[0]), 32'h0);
    check("rst.valid", 32'(val_a), 32'h0);
    check("rst.busy", 32'(busy_a), 32'h1);
    check("rst.wrdy", 32'(wrdy_a), 32'h0);
    reload(1'b1, ca, cb);
    check("busy_len16", 32'(ca), 32'd16);
    check("busy_len12", 32'(cb), 32'd12);
    for (int i = 0; i < 16; i++) begin
      set_rd(1'b1, i, 1'b0, 0);
      step();
      check($sformatf("dflt%0d", i), 32'(col_a[0]), 32'(dtab[i]));
      check($sformatf("dflt_v%0d", i), 32'(val_a[0]), 32'h1);
    end
    set_rd(1'b0, 0, 1'b0, 0);
    step();
    check("drop_init_idx2_valid_off", 32'(val_a[0]), 32'h0);

    // Write / readback
    set_wr(1'b1, 5, 8'h1c); step();
    set_wr(1'b0, 0, 8'h00);
    set_rd(1'b1, 5, 1'b1, 5); step();
    check("wb.p0", 32'(col_a[0]), 32'h1c);
    check("wb.p1", 32'(col_a[1]), 32'h1c);
    set_rd(1'b1, 4, 1'b0, 0); step();
    check("wb.idx4", 32'(col_a[0]), 32'h00);

    // Same-cycle collision
    set_wr(1'b1, 9, 8'h55);
    set_rd(1'b1, 8, 1'b1, 9); step();
    set_wr(1'b0, 0, 8'h00);
    check("coll.p1", 32'(col_a[1]), 32'h55);
    check("coll.p0", 32'(col_a[0]), 32'h00);
    check("coll.b.p1", 32'(col_b[1]), 32'h55);

    // Out-of-range on the 12-entry instance
    set_wr(1'b1, 13, 8'h77);
    set_rd(1'b0, 0, 1'b0, 0); step();
    set_wr(1'b0, 0, 8'h00);
    set_rd(1'b1, 13, 1'b0, 0); step();
    check("oor.b.color", 32'(col_b[0]), 32'h00);
    check("oor.b.valid", 32'(val_b[0]), 32'h1);
    check("oor.a.color", 32'(col_a[0]), 32'h77);

    // Mid-operation reset
    set_wr(1'b1, 1, 8'ha0);
    set_rd(1'b0, 0, 1'b0, 0); step();
    set_wr(1'b1, 3, 8'h12);
    set_rd(1'b1, 1, 1'b0, 0);
    rst = 1'b1; step();
    check("mid.valid", 32'(val_a[0]), 32'h0);
    check("mid.busy", 32'(busy_a), 32'h1);
    set_rd(1'b0, 0, 1'b0, 0);
    reload(1'b0, ca, cb);
    check("mid.len16", 32'(ca), 32'd16);
    set_rd(1'b1, 1, 1'b1, 3); step();
    check("mid.idx1", 32'(col_a[0]), 32'h07);
    check("mid.idx3", 32'(col_a[1]), 32'hef);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      set_rd(1'($urandom), $urandom_range(0, 15), 1'($urandom), $urandom_range(0, 15));
      set_wr(1'($urandom), $urandom_range(0, 15), 8'($urandom));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
